// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Brief    : Shared types for the pipelined N-to-2**N decoder: decode mode
//             encoding and the output buffer occupancy states.
//  Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // Decode mode, encoded exactly as the 2-bit in_mode port value
    typedef enum logic [1:0] {
        ONEHOT   = 2'b00,
        THERMO   = 2'b01,
        ONEHOT_N = 2'b10,
        RSVD     = 2'b11
    } mode_e;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } buf_state_e;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decode_core.sv
`default_nettype none
// ============================================================================
//  Module   : decode_core
//  Brief    : Purely combinational N-to-2**N decoder supporting one-hot,
//             thermometer and active-low one-hot modes; the reserved mode
//             yields an all-zero word.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_core
    import decoder_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]      a,
    input  mode_e             mode,
    output logic [(2**N)-1:0] y
);

    localparam int c_width = 2**N;

    // Each output bit is decided from its own index compared against the code
    always_comb begin
        y = '0;
        for (int i = 0; i < c_width; i++) begin
            case (mode)
                ONEHOT:   y[i] = (a == i[N-1:0]);
                THERMO:   y[i] = (a >= i[N-1:0]);
                ONEHOT_N: y[i] = (a != i[N-1:0]);
                default:  y[i] = 1'b0;
            endcase
        end
    end

endmodule : decode_core
`default_nettype wire

// File: rtl/decoder_nx_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_nx_pipe
//  Brief    : Valid/ready pipelined decoder. Codes are decoded on acceptance
//             and held in a 2-entry buffer; counts completed output transfers
//             and flags any accepted reserved-mode code until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_nx_pipe
    import decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_a,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(2**N)-1:0]    out_y,
    output logic [CNT_W-1:0]     count,
    output logic                 err_sticky
);

    localparam int c_width = 2**N;

    buf_state_e           r_state_q,     w_state_d;
    logic [c_width-1:0]   r_head_q,      w_head_d;
    logic [c_width-1:0]   r_tail_q,      w_tail_d;
    logic                 r_in_ready_q,  w_in_ready_d;
    logic                 r_out_valid_q, w_out_valid_d;
    logic [CNT_W-1:0]     r_count_q,     w_count_d;
    logic                 r_err_q,       w_err_d;

    logic [c_width-1:0]   w_dec;
    mode_e                w_mode;
    logic                 w_push;
    logic                 w_pop;

    assign w_mode = mode_e'(in_mode);
    assign w_push = in_valid & r_in_ready_q;
    assign w_pop  = r_out_valid_q & out_ready;

    decode_core #(
        .N (N)
    ) u_decode_core (
        .a    (in_a),
        .mode (w_mode),
        .y    (w_dec)
    );

    // Buffer occupancy, contents, handshake flags and status for next cycle
    always_comb begin
        w_state_d = r_state_q;
        w_head_d  = r_head_q;
        w_tail_d  = r_tail_q;
        w_count_d = r_count_q;
        w_err_d   = r_err_q;

        case (r_state_q)
            EMPTY: begin
                if (w_push) begin
                    w_state_d = ONE;
                    w_head_d  = w_dec;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    // Head leaves while the new word takes its place
                    w_head_d = w_dec;
                end else if (w_push) begin
                    w_state_d = FULL;
                    w_tail_d  = w_dec;
                end else if (w_pop) begin
                    w_state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen
                if (w_pop) begin
                    w_state_d = ONE;
                    w_head_d  = r_tail_q;
                end
            end
            default: begin
                w_state_d = EMPTY;
            end
        endcase

        if (w_pop) begin
            w_count_d = r_count_q + CNT_W'(1);
        end
        if (w_push && (w_mode == RSVD)) begin
            w_err_d = 1'b1;
        end

        w_in_ready_d  = (w_state_d != FULL);
        w_out_valid_d = (w_state_d != EMPTY);
    end

    // State registers with synchronous reset discarding all buffered words
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= EMPTY;
            r_head_q      <= '0;
            r_tail_q      <= '0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
            r_count_q     <= '0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_head_q      <= w_head_d;
            r_tail_q      <= w_tail_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_count_q     <= w_count_d;
            r_err_q       <= w_err_d;
        end
    end

    assign in_ready   = r_in_ready_q;
    assign out_valid  = r_out_valid_q;
    assign out_y      = r_out_valid_q ? r_head_q : '0;
    assign count      = r_count_q;
    assign err_sticky = r_err_q;

endmodule : decoder_nx_pipe
`default_nettype wire

// File: tb/tb_decoder_nx_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_nx_pipe
//  Brief    : Scoreboard bench for decoder_nx_pipe (N=3, narrow counter so
//             the wrap is exercised). Expected words come from an arithmetic
//             reference decode and a queue of accepted-but-not-delivered
//             words.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_nx_pipe;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_y;
    logic [CNT_W-1:0] count;
    logic             err_sticky;

    int               n_checks;
    int               n_errors;
    logic             mon_en;

    logic [W-1:0]     sb_q[$];
    logic [CNT_W-1:0] m_count;
    logic             m_err;
    logic             hold_pending;
    logic [W-1:0]     hold_val;

    decoder_nx_pipe #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .count      (count),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the mode definitions using plain integer arithmetic
    function automatic logic [W-1:0] ref_decode(input int a, input int mode);
        int v;
        case (mode)
            0:       v = 1 << a;
            1:       v = (1 << (a + 1)) - 1;
            2:       v = ~(1 << a);
            default: v = 0;
        endcase
        return W'(v);
    endfunction

    // Monitor: observe between edges, compare, then record what the next edge transfers
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
            chk("count", 64'(count), 64'(m_count));
            chk("err_sticky", 64'(err_sticky), 64'(m_err));
            if (!out_valid) chk("out_y_idle", 64'(out_y), 64'd0);
            if (hold_pending && out_valid) chk("out_y_hold", 64'(out_y), 64'(hold_val));
            hold_pending = out_valid && !out_ready && !reset;
            hold_val     = out_y;
            if (reset) begin
                sb_q.delete();
                m_count = '0;
                m_err   = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() > 0) chk("out_y", 64'(out_y), 64'(sb_q.pop_front()));
                    m_count = m_count + 1'b1;
                end
                if (in_valid && in_ready) begin
                    sb_q.push_back(ref_decode(int'(in_a), int'(in_mode)));
                    if (in_mode == 2'b11) m_err = 1'b1;
                end
            end
        end
    end

    // Offer one code until accepted, bounded by a cycle budget
    task automatic send(input int a, input int m);
        int   t;
        logic acc;
        t        = 0;
        in_valid = 1'b1;
        in_a     = a[N-1:0];
        in_mode  = m[1:0];
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        mon_en       = 1'b0;
        m_count      = '0;
        m_err        = 1'b0;
        hold_pending = 1'b0;
        hold_val     = '0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_mode      = '0;
        out_ready    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Basic modes with downstream always ready
        out_ready = 1'b1;
        send(3, 0);
        idle(2);
        send(5, 1);
        send(0, 2);
        idle(2);

        // Backpressure: two words fill the buffer, third waits upstream
        out_ready = 1'b0;
        send(1, 0);
        send(2, 0);
        fork
            send(4, 0);
            begin
                idle(3);
                out_ready = 1'b1;
            end
        join
        idle(3);

        // Reserved mode raises the sticky flag, later valid modes keep it
        send(6, 3);
        send(2, 0);
        send(7, 1);
        idle(2);

        // Fill to FULL, then reset with handshakes offered during the reset cycle
        out_ready = 1'b0;
        send(5, 2);
        send(6, 2);
        idle(1);
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        idle(1);
        reset     = 1'b0;
        in_valid  = 1'b0;
        idle(2);

        // Back-to-back one-hot stream
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(i, 0);
        idle(3);

        // Randomized traffic with occasional reset
        repeat (600) begin
            int r;
            r         = int'($urandom_range(0, 19));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = N'($urandom_range(0, 7));
            in_mode   = (r == 0) ? 2'b11 : 2'(r % 3);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 149) == 0);
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(5);

        @(negedge clk);
        #1;
        chk("drain", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_decoder_nx_pipe
`default_nettype wire
